// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
// Holds the control FSM encoding and step-counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int cnt_w(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle of the serial adder.
// master drives operands and out_ready; slave is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder, the cell chained inside the serial adder.
// Purely combinational.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder.sv
// Serial adder/subtractor: CHUNK bits per clock, WIDTH/CHUNK steps.
// Results are shifted in from the MSB end and shown only in DONE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_w(WIDTH, CHUNK);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] s;

  assign c[0] = carry_q;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_q[i]),
      .b_i (b_q[i]),
      .c_i (c[i]),
      .s_o (s[i]),
      .c_o (c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtract is A + ~B + 1, so c_in is ignored then.
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          sum_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = (sum_q >> CHUNK)
                | (WIDTH'(s) << (WIDTH - CHUNK));
        carry_d = c[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          ovf_d   = c[CHUNK] ^ c[CHUNK-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = bus.out_valid ? sum_q : '0;
  assign bus.c_out     = bus.out_valid & carry_q;
  assign bus.overflow  = bus.out_valid & ovf_q;

endmodule
